// File: rtl/serial_subtractor.sv
// Sequential WIDTH-bit subtractor: difference = a - b - borrow_in, CHUNK bits per clock, LSB first.
// Start/busy/done handshake; result, final borrow and signed overflow are held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_bchain;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_ovf;

  logic [CHUNK:0]     w_sub;
  logic [WIDTH-1:0]   w_a_next;
  logic [WIDTH-1:0]   w_b_next;
  logic               w_last;
  logic               w_accept;

  assign w_sub    = {1'b0, r_a_sh[CHUNK-1:0]} - {1'b0, r_b_sh[CHUNK-1:0]}
                  - {{CHUNK{1'b0}}, r_bchain};
  assign w_last   = (r_cnt == CNT_W'(N - 1));
  assign w_accept = start && (r_state != S_RUN);

  // The minuend register doubles as the result register: consumed chunks leave
  // from the bottom while difference chunks enter from the top.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign w_a_next = w_sub[CHUNK-1:0];
      assign w_b_next = '0;
    end else begin : g_multi
      assign w_a_next = {w_sub[CHUNK-1:0], r_a_sh[WIDTH-1:CHUNK]};
      assign w_b_next = {{CHUNK{1'b0}}, r_b_sh[WIDTH-1:CHUNK]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_bchain <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
      r_bchain <= borrow_in;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= w_a_next;
      r_b_sh   <= w_b_next;
      r_bchain <= w_sub[CHUNK];
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff   <= w_a_next;
        r_borrow <= w_sub[CHUNK];
        r_ovf    <= (r_a_msb != r_b_msb) && (w_a_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign difference = r_diff;
  assign borrow     = r_borrow;
  assign overflow   = r_ovf;

endmodule
